// File: rtl/dvfs_pkg.sv
// Shared constants and types for the DVFS programmable clock divider.
// Level constants are half-period-minus-one values (ratio = 2*(half+1)).
package dvfs_pkg;

   localparam int HALF_W_DEF = 4;

   localparam int HALF_DIV2  = 0;
   localparam int HALF_DIV4  = 1;
   localparam int HALF_DIV8  = 3;
   localparam int HALF_DIV16 = 7;

   // Bit 0 is the clk_out level, so the output is taken straight from a flop.
   typedef enum logic [1:0] {
      ST_LOW  = 2'b00,
      ST_HIGH = 2'b01,
      ST_PARK = 2'b10
   } pcd_state_e;

endpackage

// File: rtl/pcd_req_slot.sv
// One-entry holding register for ratio-change requests.
// Accepts when empty, releases its entry when the divider applies it.
module pcd_req_slot
   import dvfs_pkg::*;
#(
   parameter int HALF_W = HALF_W_DEF
)(
   input  logic              clk_in,
   input  logic              rst,
   input  logic              req_valid,
   input  logic [HALF_W-1:0] req_half,
   output logic              req_ready,
   input  logic              clear,
   output logic [HALF_W-1:0] pend_half,
   output logic              pending
);

   logic              r_pending;
   logic [HALF_W-1:0] r_pend_half;
   logic              w_accept;

   // Accept and clear are mutually exclusive: one needs the slot empty, the other full.
   assign w_accept = req_valid && !r_pending;

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         r_pending   <= 1'b0;
         r_pend_half <= '0;
      end else begin
         if (w_accept) begin
            r_pending   <= 1'b1;
            r_pend_half <= req_half;
         end else if (clear) begin
            r_pending   <= 1'b0;
         end
      end
   end

   assign req_ready = !r_pending;
   assign pend_half = r_pend_half;
   assign pending   = r_pending;

endmodule

// File: rtl/prog_clock_divider.sv
// Runtime-programmable even-ratio clock divider with glitch-free ratio changes
// at period boundaries, enable/park control, rise tick and apply pulse.
module prog_clock_divider
   import dvfs_pkg::*;
#(
   parameter int HALF_W   = HALF_W_DEF,
   parameter int HALF_RST = HALF_DIV2
)(
   input  logic              clk_in,
   input  logic              rst,
   input  logic              en,
   input  logic              req_valid,
   input  logic [HALF_W-1:0] req_half,
   output logic              req_ready,
   output logic              clk_out,
   output logic              tick,
   output logic              cfg_done,
   output logic [HALF_W-1:0] cur_half
);

   localparam logic [HALF_W-1:0] L_HALF_RST = HALF_W'(HALF_RST);

   pcd_state_e        r_state;
   pcd_state_e        w_state_next;
   logic [HALF_W-1:0] r_cnt;
   logic [HALF_W-1:0] w_cnt_next;
   logic [HALF_W-1:0] r_half_cur;
   logic [HALF_W-1:0] w_half_next;
   logic              r_tick;
   logic              w_tick_next;
   logic              r_cfg_done;
   logic              w_cfg_done_next;
   logic [HALF_W-1:0] w_pend_half;
   logic              w_pending;
   logic              w_boundary;
   logic              w_apply;

   pcd_req_slot #(
      .HALF_W    (HALF_W)
   ) u_req_slot (
      .clk_in    (clk_in),
      .rst       (rst),
      .req_valid (req_valid),
      .req_half  (req_half),
      .req_ready (req_ready),
      .clear     (w_apply),
      .pend_half (w_pend_half),
      .pending   (w_pending)
   );

   // Boundary is the last low cycle; while parked it stays true every cycle.
   assign w_boundary = (r_cnt == r_half_cur) && (r_state != ST_HIGH);
   assign w_apply    = w_boundary && w_pending;

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         r_state    <= ST_LOW;
         r_cnt      <= '0;
         r_half_cur <= L_HALF_RST;
         r_tick     <= 1'b0;
         r_cfg_done <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_cnt      <= w_cnt_next;
         r_half_cur <= w_half_next;
         r_tick     <= w_tick_next;
         r_cfg_done <= w_cfg_done_next;
      end
   end

   always_comb begin
      w_state_next    = r_state;
      w_cnt_next      = r_cnt + 1'b1;
      w_half_next     = r_half_cur;
      w_tick_next     = 1'b0;
      w_cfg_done_next = 1'b0;

      if (w_apply) begin
         w_half_next     = w_pend_half;
         w_cfg_done_next = 1'b1;
      end

      case (r_state)
         ST_HIGH: begin
            if (r_cnt == r_half_cur) begin
               w_state_next = ST_LOW;
               w_cnt_next   = '0;
            end
         end
         ST_LOW, ST_PARK: begin
            if (w_boundary) begin
               if (en) begin
                  w_state_next = ST_HIGH;
                  w_cnt_next   = '0;
                  w_tick_next  = 1'b1;
               end else begin
                  // Keep cnt pinned to the (possibly new) half so the park holds.
                  w_state_next = ST_PARK;
                  w_cnt_next   = w_half_next;
               end
            end
         end
         default: begin
            w_state_next = ST_LOW;
            w_cnt_next   = '0;
         end
      endcase
   end

   always_comb begin
      clk_out  = r_state[0];
      tick     = r_tick;
      cfg_done = r_cfg_done;
      cur_half = r_half_cur;
   end

endmodule

// File: tb/tb_prog_clock_divider.sv
// Scoreboard bench: a phase-duration reference model predicts each cycle's outputs,
// a monitor pops and compares after every rising edge.
module tb_prog_clock_divider;
   import dvfs_pkg::*;

   localparam int HW   = HALF_W_DEF;
   localparam int HRST = HALF_DIV2;

   logic          clk_in = 1'b0;
   logic          rst = 1'b1;
   logic          en = 1'b0;
   logic          req_valid = 1'b0;
   logic [HW-1:0] req_half = '0;
   logic          req_ready;
   logic          clk_out;
   logic          tick;
   logic          cfg_done;
   logic [HW-1:0] cur_half;

   prog_clock_divider #(
      .HALF_W   (HW),
      .HALF_RST (HRST)
   ) dut (
      .clk_in    (clk_in),
      .rst       (rst),
      .en        (en),
      .req_valid (req_valid),
      .req_half  (req_half),
      .req_ready (req_ready),
      .clk_out   (clk_out),
      .tick      (tick),
      .cfg_done  (cfg_done),
      .cur_half  (cur_half)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      bit clk;
      bit tck;
      bit done;
      int half;
      bit ready;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   bit   en_cur = 1'b1;

   // Reference model: output level plus cycles remaining in the current level.
   bit m_out;
   int m_left;
   int m_half;
   bit m_pend;
   int m_pend_half;

   task automatic chk(input string name, input int act, input int expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, expv);
      end
   endtask

   task automatic model_reset();
      m_out  = 1'b0;
      m_left = HRST + 1;
      m_half = HRST;
      m_pend = 1'b0;
   endtask

   // Advance the model across one rising edge using the inputs now on the pins.
   task automatic step(output bit acc);
      exp_t e;
      bit   last_low;
      e.tck    = 1'b0;
      e.done   = 1'b0;
      last_low = (m_out == 1'b0) && (m_left == 1);
      acc      = req_valid && !m_pend;
      if (last_low) begin
         if (m_pend) begin
            m_half = m_pend_half;
            m_pend = 1'b0;
            e.done = 1'b1;
         end
         if (en) begin
            m_out  = 1'b1;
            m_left = m_half + 1;
            e.tck  = 1'b1;
         end
      end else if (m_left == 1) begin
         m_out  = 1'b0;
         m_left = m_half + 1;
      end else begin
         m_left--;
      end
      if (acc) begin
         m_pend      = 1'b1;
         m_pend_half = int'(req_half);
      end
      e.clk   = m_out;
      e.half  = m_half;
      e.ready = !m_pend;
      exp_q.push_back(e);
   endtask

   task automatic run(input int n);
      bit acc;
      for (int i = 0; i < n; i++) begin
         @(negedge clk_in);
         en        = en_cur;
         req_valid = 1'b0;
         step(acc);
      end
   endtask

   // Requester holds valid and data until the handshake completes.
   task automatic request(input int h);
      bit acc;
      int n;
      n = 0;
      acc = 1'b0;
      while (!acc && n < 200) begin
         @(negedge clk_in);
         en        = en_cur;
         req_valid = 1'b1;
         req_half  = HW'(h);
         step(acc);
         n++;
      end
      if (!acc) begin
         checks++;
         errors++;
         $display("FAIL req_accept_timeout at %0t: got no acceptance, expected one within 200 cycles", $time);
      end else begin
         $display("%0t: request half=%0d en=%0d accepted after %0d cycle(s)", $time, h, en_cur, n);
      end
   endtask

   task automatic do_reset(input int n);
      bit acc;
      @(negedge clk_in);
      #2;
      rst = 1'b1;
      exp_q.delete();
      model_reset();
      #1;
      chk("rst_clk_out", int'(clk_out), 0);
      chk("rst_tick", int'(tick), 0);
      chk("rst_cfg_done", int'(cfg_done), 0);
      chk("rst_cur_half", int'(cur_half), HRST);
      chk("rst_req_ready", int'(req_ready), 1);
      repeat (n) @(negedge clk_in);
      rst       = 1'b0;
      en        = en_cur;
      req_valid = 1'b0;
      step(acc);
      $display("%0t: reset released", $time);
   endtask

   exp_t mon_e;
   always @(posedge clk_in) begin
      #1;
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         chk("clk_out", int'(clk_out), int'(mon_e.clk));
         chk("tick", int'(tick), int'(mon_e.tck));
         chk("cfg_done", int'(cfg_done), int'(mon_e.done));
         chk("cur_half", int'(cur_half), mon_e.half);
         chk("req_ready", int'(req_ready), int'(mon_e.ready));
         if (mon_e.done)
            $display("%0t: ratio applied, half=%0d", $time, mon_e.half);
      end
   end

   initial begin
      int r;
      int n;
      model_reset();
      en_cur = 1'b1;
      en     = 1'b1;
      do_reset(3);
      run(9);
      // Back-to-back requests: the second is held until the first is applied.
      request(HALF_DIV8);
      request(HALF_DIV16);
      run(40);
      request(HALF_DIV4);
      run(12);
      n = 0;
      while (!m_out && n < 50) begin
         run(1);
         n++;
      end
      en_cur = 1'b0;
      run(10);
      request(HALF_DIV16);
      run(4);
      en_cur = 1'b1;
      run(40);
      // Reset while a request is still pending.
      request(2);
      run(2);
      do_reset(2);
      run(10);
      for (int it = 0; it < 300; it++) begin
         r = int'($urandom_range(0, 99));
         if (r < 30)
            request(int'($urandom_range(0, (1 << HW) - 1)));
         else if (r < 42)
            en_cur = ($urandom_range(0, 3) != 0);
         else if (r < 45)
            do_reset(int'($urandom_range(1, 3)));
         else
            run(int'($urandom_range(1, 8)));
      end
      en_cur = 1'b1;
      run(5);
      @(posedge clk_in);
      #2;
      chk("queue_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
